// File: rtl/chipout_scheduler.sv
// rtl/chipout_scheduler.sv - round-robin scheduler driving the 6-bit chip output bus
//
// Grants one of NREQ word sources at a time, latches its 5-bit word and drives
// databus with a setup / strobe / hold sequence (bit 5 = DATAREADY).
//
// Ports:
//   CLK       in   clock
//   RST       in   asynchronous active-high reset
//   en        in   allow new grants (an ongoing transfer always completes)
//   req       in   [NREQ-1:0] request per source, held until its ack
//   words     in   [5*NREQ-1:0] packed words, source i at [5i+4:5i]
//   ack       out  [NREQ-1:0] one-cycle one-hot grant/capture pulse
//   databus   out  [5:0] word in [4:0], DATAREADY in [5]
//   busy      out  high whenever the FSM is not idle
//   grant_id  out  [2:0] index of the current or most recent grantee
module chipout_scheduler #(
    parameter int NREQ       = 4,
    parameter int SETUP_CYC  = 2,
    parameter int STROBE_CYC = 4,
    parameter int HOLD_CYC   = 2
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                en,
    input  logic [NREQ-1:0]     req,
    input  logic [5*NREQ-1:0]   words,
    output logic [NREQ-1:0]     ack,
    output logic [5:0]          databus,
    output logic                busy,
    output logic [2:0]          grant_id
);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    state_t          state, state_nxt;
    logic [7:0]      cnt, cnt_nxt;
    logic [2:0]      ptr, ptr_nxt;
    logic [NREQ-1:0] ack_nxt;
    logic [5:0]      databus_nxt;
    logic [2:0]      grant_id_nxt;

    // Zero-extended copies so a 3-bit index never selects past the real vector.
    logic [7:0]      req_ext;
    logic [39:0]     words_ext;
    logic            found;
    logic [2:0]      winner;
    logic [3:0]      idx;
    logic [3:0]      winner_p1;
    logic [4:0]      win_word;

    assign req_ext   = 8'(req);
    assign words_ext = 40'(words);

    // Round-robin search: start at ptr, increase, wrap at NREQ-1 -> 0.
    always_comb begin
        found  = 1'b0;
        winner = 3'd0;
        idx    = 4'd0;
        for (int i = 0; i < NREQ; i++) begin
            idx = {1'b0, ptr} + 4'(i);
            if (idx >= 4'(NREQ)) begin
                idx = idx - 4'(NREQ);
            end
            if (!found && req_ext[idx[2:0]]) begin
                found  = 1'b1;
                winner = idx[2:0];
            end
        end
    end

    assign winner_p1 = {1'b0, winner} + 4'd1;
    assign win_word  = words_ext[winner*5 +: 5];

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        ptr_nxt      = ptr;
        ack_nxt      = '0;
        databus_nxt  = databus;
        grant_id_nxt = grant_id;
        case (state)
            IDLE: begin
                databus_nxt = 6'd0;
                if (en && found) begin
                    state_nxt    = SETUP;
                    cnt_nxt      = 8'(SETUP_CYC - 1);
                    ptr_nxt      = (winner_p1 == 4'(NREQ)) ? 3'd0 : winner_p1[2:0];
                    ack_nxt      = NREQ'(1) << winner;
                    databus_nxt  = {1'b0, win_word};
                    grant_id_nxt = winner;
                end
            end
            SETUP: begin
                if (cnt == 8'd0) begin
                    state_nxt      = STROBE;
                    cnt_nxt        = 8'(STROBE_CYC - 1);
                    databus_nxt[5] = 1'b1;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            STROBE: begin
                if (cnt == 8'd0) begin
                    state_nxt      = HOLD;
                    cnt_nxt        = 8'(HOLD_CYC - 1);
                    databus_nxt[5] = 1'b0;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            HOLD: begin
                if (cnt == 8'd0) begin
                    state_nxt   = IDLE;
                    databus_nxt = 6'd0;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            default: begin
                state_nxt   = IDLE;
                databus_nxt = 6'd0;
            end
        endcase
    end

    // busy is registered from the next state so it tracks the FSM without lag.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            cnt      <= 8'd0;
            ptr      <= 3'd0;
            ack      <= '0;
            databus  <= 6'd0;
            busy     <= 1'b0;
            grant_id <= 3'd0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            ptr      <= ptr_nxt;
            ack      <= ack_nxt;
            databus  <= databus_nxt;
            busy     <= (state_nxt != IDLE);
            grant_id <= grant_id_nxt;
        end
    end

endmodule

// File: tb/tb_chipout_scheduler.sv
// tb/tb_chipout_scheduler.sv - scoreboard bench for chipout_scheduler
module tb_chipout_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [3:0]  req;
    logic [19:0] words;
    logic [3:0]  ack;
    logic [5:0]  databus;
    logic        busy;
    logic [2:0]  grant_id;

    logic [7:0]  req_b;
    logic [39:0] words_b;
    logic [7:0]  ack_b;
    logic [5:0]  databus_b;
    logic        busy_b;
    logic [2:0]  grant_id_b;

    always #5 clk = ~clk;

    chipout_scheduler u_dut (
        .CLK(clk), .RST(rst), .en(en), .req(req), .words(words),
        .ack(ack), .databus(databus), .busy(busy), .grant_id(grant_id)
    );

    chipout_scheduler #(.NREQ(8), .SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(1)) u_dut_b (
        .CLK(clk), .RST(rst), .en(en), .req(req_b), .words(words_b),
        .ack(ack_b), .databus(databus_b), .busy(busy_b), .grant_id(grant_id_b)
    );

    typedef struct {
        int         id;
        logic [4:0] word;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int id, input logic [4:0] word);
        exp_t e;
        e.id   = id;
        e.word = word;
        exp_q.push_back(e);
    endtask

    task automatic wait_ack(input string tag, output int waited);
        waited = 0;
        do begin
            tick();
            waited++;
        end while (ack == 4'd0 && waited < 30);
        check({tag, "_ack_seen"}, 32'(ack != 4'd0), 32'd1);
    endtask

    // Pops the expected grant and checks the full 9-cycle bus waveform.
    task automatic expect_transfer(input string tag, input int en_drop_at, input int rst_at);
        exp_t       e;
        logic [5:0] want;
        check({tag, "_sb_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        check({tag, "_ack"}, 32'(ack), 32'(4'd1 << e.id));
        check({tag, "_ack_onehot"}, 32'($countones(ack)), 32'd1);
        check({tag, "_grant_id"}, 32'(grant_id), 32'(e.id));
        check({tag, "_s0_bus"}, 32'(databus), 32'({1'b0, e.word}));
        check({tag, "_s0_busy"}, 32'(busy), 32'd1);
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 8)                want = 6'd0;
            else if (k >= 2 && k <= 5) want = {1'b1, e.word};
            else                       want = {1'b0, e.word};
            check($sformatf("%s_s%0d_bus", tag, k), 32'(databus), 32'(want));
            if (k == 1) check({tag, "_ack_clear"}, 32'(ack), 32'd0);
            if (k == 8) check({tag, "_busy_fall"}, 32'(busy), 32'd0);
            if (k == en_drop_at) en = 1'b0;
            if (k == rst_at) begin
                rst = 1'b1;
                #1;
                check({tag, "_rst_bus"}, 32'(databus), 32'd0);
                check({tag, "_rst_busy"}, 32'(busy), 32'd0);
                check({tag, "_rst_ack"}, 32'(ack), 32'd0);
                return;
            end
        end
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        int         w;
        logic [3:0] acc;

        rst     = 1'b1;
        en      = 1'b0;
        req     = 4'd0;
        words   = 20'd0;
        req_b   = 8'd0;
        words_b = 40'd0;
        tick();
        tick();
        check("rst_bus", 32'(databus), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_gid", 32'(grant_id), 32'd0);
        check("rst_b_bus", 32'(databus_b), 32'd0);
        rst = 1'b0;
        tick();

        // Single request, word captured and later changes ignored.
        words[9:5] = 5'h15;
        en  = 1'b1;
        req = 4'b0010;
        push_exp(1, 5'h15);
        wait_ack("t1", w);
        req        = 4'd0;
        words[9:5] = 5'h0a;
        expect_transfer("t1", -1, -1);
        check("t1_gid_after", 32'(grant_id), 32'd1);

        // All four requesting continuously.
        reset_pulse();
        words = {5'd4, 5'd3, 5'd2, 5'd1};
        req   = 4'hf;
        push_exp(0, 5'd1);
        push_exp(1, 5'd2);
        push_exp(2, 5'd3);
        push_exp(3, 5'd4);
        push_exp(0, 5'd1);
        for (int g = 0; g < 5; g++) begin
            wait_ack("t2", w);
            check($sformatf("t2_period_%0d", g), 32'(w), 32'd1);
            if (g == 4) req = 4'd0;
            expect_transfer($sformatf("t2_g%0d", g), -1, -1);
        end

        // Round-robin wrap: pointer at 3, then 0 and 2 requesting.
        reset_pulse();
        req = 4'b0100;
        push_exp(2, 5'd3);
        wait_ack("t3a", w);
        req = req & ~ack;
        expect_transfer("t3a", -1, -1);
        req = 4'b0101;
        push_exp(0, 5'd1);
        push_exp(2, 5'd3);
        wait_ack("t3b", w);
        req = req & ~ack;
        expect_transfer("t3b", -1, -1);
        wait_ack("t3c", w);
        check("t3c_period", 32'(w), 32'd1);
        req = req & ~ack;
        expect_transfer("t3c", -1, -1);

        // Enable dropped during STROBE with requester 3 pending.
        req = 4'b0001;
        push_exp(0, 5'd1);
        wait_ack("t4a", w);
        req = 4'b1000;
        expect_transfer("t4a", 3, -1);
        acc = 4'd0;
        repeat (6) begin
            tick();
            acc = acc | ack;
        end
        check("t4_no_ack_while_disabled", 32'(acc), 32'd0);
        en = 1'b1;
        push_exp(3, 5'd4);
        wait_ack("t4b", w);
        check("t4b_latency", 32'(w), 32'd1);
        req = 4'd0;
        expect_transfer("t4b", -1, -1);

        // Reset in the 2nd STROBE cycle, then priority back at 0.
        req = 4'b0010;
        push_exp(1, 5'd2);
        wait_ack("t5a", w);
        req = 4'd0;
        expect_transfer("t5a", -1, 3);
        tick();
        rst = 1'b0;
        req = 4'b0011;
        push_exp(0, 5'd1);
        push_exp(1, 5'd2);
        wait_ack("t5b", w);
        req = req & ~ack;
        expect_transfer("t5b", -1, -1);
        wait_ack("t5c", w);
        req = 4'd0;
        expect_transfer("t5c", -1, -1);

        // NREQ=8, all stages one cycle.
        words_b[39:35] = 5'h0a;
        req_b = 8'h80;
        w = 0;
        do begin
            tick();
            w++;
        end while (ack_b == 8'd0 && w < 30);
        check("t6_ack", 32'(ack_b), 32'h80);
        check("t6_gid", 32'(grant_id_b), 32'd7);
        check("t6_s0_bus", 32'(databus_b), 32'h0a);
        tick();
        check("t6_s1_bus", 32'(databus_b), 32'h2a);
        tick();
        check("t6_s2_bus", 32'(databus_b), 32'h0a);
        tick();
        check("t6_s3_bus", 32'(databus_b), 32'h00);
        check("t6_s3_busy", 32'(busy_b), 32'd0);
        tick();
        check("t6_period_ack", 32'(ack_b), 32'h80);
        req_b = 8'd0;
        repeat (4) tick();
        check("t6_idle_bus", 32'(databus_b), 32'd0);

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
